// File: rtl/shifter_3bit_right_pkg.sv
// Shared ALU constants: shift opcodes and default datapath widths.
// Pure declarations; no logic, no latency.
package shifter_3bit_right_pkg;

  localparam int WIDTH_DEF   = 6;
  localparam int SHAMT_W_DEF = 3;

  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_right_core.sv
// Combinational log2 right barrel shifter (stages 1,2,4,...), logical or arithmetic fill.
// Zero latency, no flow control; amounts >= WIDTH saturate to all-fill.
module shift_right_core #(
  parameter int WIDTH   = 6,
  parameter int SHAMT_W = 3
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amt,
  input  logic               arith,
  output logic [WIDTH-1:0]   result
);

  logic             w_fill;
  logic [WIDTH-1:0] w_stage [SHAMT_W+1];

  assign w_fill     = arith & data[WIDTH-1];
  assign w_stage[0] = data;

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    // A stage wider than the word flushes it entirely, which gives saturation for free.
    if (SH >= WIDTH) begin : g_sat
      assign w_stage[s+1] = amt[s] ? {WIDTH{w_fill}} : w_stage[s];
    end else begin : g_shift
      assign w_stage[s+1] = amt[s] ? {{SH{w_fill}}, w_stage[s][WIDTH-1:SH]} : w_stage[s];
    end
  end

  assign result = w_stage[SHAMT_W];

endmodule

// File: rtl/shifter_3bit_right.sv
// SRL/SRA ALU slice: decodes the opcode, registers X and shift_op with 1-cycle latency.
// Updates every cycle, no handshake; non-shift opcodes and reset load zeros.
module shifter_3bit_right
  import shifter_3bit_right_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       instruction,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] X,
  output logic             shift_op
);

  logic             w_is_shift;
  logic             w_arith;
  logic [WIDTH-1:0] w_result;
  logic             w_unused_b;

  assign w_is_shift = is_shift_op(instruction);
  assign w_arith    = (instruction == OP_SRA);
  assign w_unused_b = ^B[WIDTH-1:SHAMT_W];

  shift_right_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data   (A),
    .amt    (B[SHAMT_W-1:0]),
    .arith  (w_arith),
    .result (w_result)
  );

  logic [WIDTH-1:0] r_x;
  logic             r_shift_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_shift_op <= 1'b0;
    end else begin
      r_x        <= w_is_shift ? w_result : '0;
      r_shift_op <= w_is_shift;
    end
  end

  assign X        = r_x;
  assign shift_op = r_shift_op;

endmodule

// File: tb/tb_shifter_3bit_right.sv
// Directed and randomised checks of shifter_3bit_right against hand values and a behavioural model.
module tb_shifter_3bit_right;

  logic       clk;
  logic       rst;
  logic [3:0] instruction;
  logic [5:0] A;
  logic [5:0] B;
  logic [5:0] X;
  logic       shift_op;

  int n_checks = 0;
  int n_pass   = 0;

  shifter_3bit_right dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .A           (A),
    .B           (B),
    .X           (X),
    .shift_op    (shift_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {op,X}=%b required %b", tag, got, exp);
  endtask

  task automatic apply(input logic r, input logic [3:0] op, input logic [5:0] a, input logic [5:0] b);
    rst = r; instruction = op; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] model(input logic r, input logic [3:0] op,
                                       input logic [5:0] a, input logic [5:0] b);
    logic [2:0] amt;
    logic [5:0] res;
    amt = b[2:0];
    if (r) return 7'b0;
    if (op == 4'b0110) begin
      res = (amt >= 3'd6) ? 6'b0 : (a >> amt);
      return {1'b1, res};
    end
    if (op == 4'b0111) begin
      if (amt >= 3'd6) res = {6{a[5]}};
      else             res = 6'($signed(a) >>> amt);
      return {1'b1, res};
    end
    return 7'b0;
  endfunction

  initial begin
    logic [3:0] op;
    logic       r;
    logic [5:0] a, b;
    string      tag;

    rst = 1'b1; instruction = 4'b0; A = 6'b0; B = 6'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_state", {shift_op, X}, 7'b0);

    apply(0, 4'b0110, 6'b111000, 6'b101010); check("srl_amt2_a",   {shift_op, X}, {1'b1, 6'b001110});
    apply(0, 4'b0110, 6'b001100, 6'b101010); check("srl_amt2_b",   {shift_op, X}, {1'b1, 6'b000011});
    apply(0, 4'b0110, 6'b111111, 6'b000111); check("srl_sat7",     {shift_op, X}, {1'b1, 6'b000000});
    apply(0, 4'b0110, 6'b111111, 6'b000110); check("srl_sat6",     {shift_op, X}, {1'b1, 6'b000000});
    apply(0, 4'b0111, 6'b101010, 6'b111000); check("sra_amt0",     {shift_op, X}, {1'b1, 6'b101010});
    apply(0, 4'b0111, 6'b111111, 6'b010010); check("sra_amt2_ones",{shift_op, X}, {1'b1, 6'b111111});
    apply(0, 4'b0111, 6'b100000, 6'b000110); check("sra_sat6",     {shift_op, X}, {1'b1, 6'b111111});
    apply(0, 4'b0111, 6'b011111, 6'b000111); check("sra_sat7_pos", {shift_op, X}, {1'b1, 6'b000000});
    apply(0, 4'b0111, 6'b100100, 6'b000001); check("sra_amt1_neg", {shift_op, X}, {1'b1, 6'b110010});
    apply(0, 4'b0110, 6'b100100, 6'b000001); check("srl_amt1",     {shift_op, X}, {1'b1, 6'b010010});
    apply(0, 4'b0000, 6'b111111, 6'b000001); check("other_op_0000",{shift_op, X}, 7'b0);
    apply(0, 4'b0101, 6'b101010, 6'b000011); check("other_op_0101",{shift_op, X}, 7'b0);
    apply(0, 4'b1111, 6'b111000, 6'b000001); check("other_op_1111",{shift_op, X}, 7'b0);

    apply(0, 4'b0111, 6'b110000, 6'b000001); check("pre_reset",    {shift_op, X}, {1'b1, 6'b111000});
    apply(1, 4'b0110, 6'b111000, 6'b000001); check("reset_prio",   {shift_op, X}, 7'b0);
    apply(0, 4'b0110, 6'b111000, 6'b000001); check("post_reset",   {shift_op, X}, {1'b1, 6'b011100});

    // Every amount on both opcodes, upper B bits set to show they are ignored.
    for (int o = 6; o <= 7; o++) begin
      for (int s = 0; s < 8; s++) begin
        op = 4'(o);
        a  = 6'b101101;
        b  = {3'b101, 3'(s)};
        apply(0, op, a, b);
        tag = $sformatf("sweep_op%0d_amt%0d", o, s);
        check(tag, {shift_op, X}, model(0, op, a, b));
      end
    end

    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'b0110;
        1:       op = 4'b0111;
        2:       op = 4'($urandom_range(0, 15));
        default: op = 4'(6 + (i % 2));
      endcase
      r = ($urandom_range(0, 31) == 0);
      a = 6'($urandom);
      b = (i < 16) ? {3'($urandom), 3'(i % 8)} : 6'($urandom);
      apply(r, op, a, b);
      tag = $sformatf("rand_%0d", i);
      check(tag, {shift_op, X}, model(r, op, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shifter_3bit_right.md
SHIFTER_3BIT_RIGHT -- requirements
Module: shifter_3bit_right

Interface
REQ-001 Parameters, name / default / meaning: WIDTH / 6 / data width of A, B, X; SHAMT_W / 3 / shift-amount width taken from B.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instruction  input  4  ALU opcode.
REQ-005 A  input  WIDTH  operand to be shifted.
REQ-006 B  input  WIDTH  shift-amount source; only B[SHAMT_W-1:0] is used.
REQ-007 X  output  WIDTH  registered shift result.
REQ-008 shift_op  output  1  registered flag, 1 when X holds a result of a shift opcode.

Function
REQ-009 Opcode 4'b0110 (SRL) SHALL produce A logically shifted right by amt = B[2:0], vacated MSBs filled with 0.
REQ-010 Opcode 4'b0111 (SRA) SHALL produce A arithmetically shifted right by amt, vacated MSBs filled with A[WIDTH-1].
REQ-011 amt >= WIDTH (6 or 7) SHALL saturate: SRL gives all zeros; SRA gives all copies of A[WIDTH-1].
REQ-012 amt = 0 SHALL pass A unchanged for both opcodes.
REQ-013 B[WIDTH-1:SHAMT_W] SHALL be ignored.
REQ-014 Any other opcode SHALL load X = 0 and shift_op = 0; it SHALL NOT hold the previous result.
REQ-015 X and shift_op SHALL be registered with one-cycle latency: inputs sampled at edge n appear on the outputs after edge n.
REQ-016 X and shift_op SHALL update every cycle; no enable and no handshake.
REQ-017 The shift SHALL be computed combinationally within one cycle as a log2 barrel shifter with stages 1, 2, 4 selected by amt bits 0, 1, 2.
REQ-018 Outputs SHALL contain no X/Z when inputs are known.

Reset
REQ-019 With rst = 1 at a rising clk edge, X SHALL become 0 and shift_op SHALL become 0.
REQ-020 rst SHALL take priority over any opcode presented in the same cycle.
REQ-021 Deasserting rst mid-stream SHALL give a valid result one cycle after the first non-reset edge.
REQ-022 rst SHALL have no asynchronous effect.

Structure
REQ-023 Opcode constants OP_SRL = 4'b0110 and OP_SRA = 4'b0111 SHALL live in the shared ALU package, together with the WIDTH default.
REQ-024 The combinational shifter SHALL be a sub-module named shift_right_core (inputs: data, amt, arith; output: result), instantiated once.
REQ-025 The top level SHALL contain only opcode decode, the output registers and reset logic.

Verification
REQ-026 SRL: instruction=0110, A=111000, B=101010 (amt 2) -> X=001110, shift_op=1 one cycle later.
REQ-027 SRL: A=001100, B=101010 -> X=000011; SRL with A=111111, B=000111 (saturated) -> X=000000.
REQ-028 SRA: instruction=0111, A=101010, B=111000 (amt 0) -> X=101010; A=111111, B=010010 -> X=111111; A=100000, B=000110 -> X=111111.
REQ-029 Other opcode: instruction=0000, any A/B -> X=000000, shift_op=0.
REQ-030 Reset: rst=1 with instruction=0110, A=111000, B=000001 -> X=000000, shift_op=0; after rst drops, X=011100 on the next cycle.
REQ-031 Randomised run of at least 1000 cycles against a reference model SHALL match exactly, including every amt value 0..7 on both opcodes.
